// File: rtl/profiler_counter_reader.sv
// Snapshots NUM_COUNTERS 32-bit counters on dump_req and streams them as a byte frame
// (header, length, payload LSB-first). Define PROFILER_READER_CHECKSUM_EN to append a sum byte.
module profiler_counter_reader #(
  parameter int         NUM_COUNTERS = 11,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [32*NUM_COUNTERS-1:0] counters_flat,
  input  logic                      dump_req,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int                NB       = 4 * NUM_COUNTERS;
  localparam int                IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0]        LEN_BYTE = 8'(NB % 256);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    LENGTH   = 3'd2,
    PAYLOAD  = 3'd3
`ifdef PROFILER_READER_CHECKSUM_EN
    ,CHECKSUM = 3'd4
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [32*NUM_COUNTERS-1:0] snap_q, snap_d;
  logic                      done_q, done_d;
  logic                      overrun_q, overrun_d;
  logic [7:0]                byte_s;
  logic                      xfer_s;
`ifdef PROFILER_READER_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  // Byte presented for the current state; derived only from registered state.
  always_comb begin
    byte_s = 8'h00;
    case (state_q)
      IDLE:     byte_s = 8'h00;
      HEADER:   byte_s = HEADER_BYTE;
      LENGTH:   byte_s = LEN_BYTE;
      PAYLOAD:  byte_s = snap_q[{idx_q, 3'b000} +: 8];
`ifdef PROFILER_READER_CHECKSUM_EN
      CHECKSUM: byte_s = csum_q;
`endif
      default:  byte_s = 8'h00;
    endcase
  end

  // Frame sequencing, snapshot capture and overrun tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    xfer_s    = (state_q != IDLE) && tx_ready;
`ifdef PROFILER_READER_CHECKSUM_EN
    csum_d    = csum_q;
    if (xfer_s && (state_q != CHECKSUM)) begin
      csum_d = csum_q + byte_s;
    end else begin
      csum_d = csum_q;
    end
`endif
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          snap_d    = counters_flat;
          overrun_d = 1'b0;
          idx_d     = '0;
          state_d   = HEADER;
`ifdef PROFILER_READER_CHECKSUM_EN
          csum_d    = 8'h00;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      HEADER: begin
        if (tx_ready) state_d = LENGTH;
        else          state_d = HEADER;
      end
      LENGTH: begin
        if (tx_ready) state_d = PAYLOAD;
        else          state_d = LENGTH;
      end
      PAYLOAD: begin
        if (tx_ready && (idx_q == LAST_IDX)) begin
          idx_d   = '0;
`ifdef PROFILER_READER_CHECKSUM_EN
          state_d = CHECKSUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else if (tx_ready) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
`ifdef PROFILER_READER_CHECKSUM_EN
      CHECKSUM: begin
        if (tx_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = CHECKSUM;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A request arriving mid-frame is dropped but remembered.
    if ((state_q != IDLE) && dump_req) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PROFILER_READER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef PROFILER_READER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign tx_data  = byte_s;
  assign tx_valid = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_profiler_counter_reader.sv
// Randomized bench for profiler_counter_reader: a queue-based frame model predicts every
// output cycle by cycle; inputs change on the falling edge, outputs are checked there too.
module tb_profiler_counter_reader;
  localparam int N  = 11;
  localparam int NB = 4 * N;
`ifdef PROFILER_READER_CHECKSUM_EN
  localparam int FRAME_LEN = NB + 3;
`else
  localparam int FRAME_LEN = NB + 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [32*N-1:0] counters_flat;
  logic           dump_req, tx_ready;
  logic [7:0]     tx_data;
  logic           tx_valid, busy, done, overrun;

  always #5 clk = ~clk;

  profiler_counter_reader #(.NUM_COUNTERS(N), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .counters_flat(counters_flat), .dump_req(dump_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]      exp_q[$];
  bit              m_busy, m_done, m_ovr;
  int              sent, xfers_seen;
  logic [32*N-1:0] cnt_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("tx_data", {24'd0, tx_data}, {24'd0, (m_busy ? exp_q[0] : 8'h00)});
    if (done) begin
      chk("frame_len", xfers_seen, FRAME_LEN);
      xfers_seen = 0;
    end
  endtask

  // Predict the effect of the coming rising edge from the frame-level rules.
  task automatic model_edge();
    logic [7:0] s;
    m_done = 1'b0;
    if (!m_busy) begin
      if (dump_req) begin
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NB));
        for (int b = 0; b < NB; b++) exp_q.push_back(counters_flat[8*b +: 8]);
`ifdef PROFILER_READER_CHECKSUM_EN
        s = 8'h00;
        for (int i = 0; i < exp_q.size(); i++) s = s + exp_q[i];
        exp_q.push_back(s);
`endif
        m_busy = 1'b1;
        m_ovr  = 1'b0;
        sent   = 0;
      end
    end else begin
      if (dump_req) m_ovr = 1'b1;
      if (tx_ready) begin
        void'(exp_q.pop_front());
        sent++;
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic dreq, input logic rdy);
    @(negedge clk);
    compare_outputs();
    if (tx_valid && rdy) xfers_seen++;
    dump_req      = dreq;
    tx_ready      = rdy;
    counters_flat = cnt_next;
    model_edge();
  endtask

  task automatic run_frame(input bit rand_cnt, input int stall_at, input bit rand_rdy,
                           input bit poke_dreq);
    int   stall;
    int   guard;
    logic rdy;
    logic dq;
    stall = 0;
    guard = 0;
    step(1'b1, 1'b1);
    while (m_busy && guard < 400) begin
      rdy = 1'b1;
      dq  = 1'b0;
      if (rand_cnt) for (int k = 0; k < N; k++) cnt_next[32*k +: 32] = $urandom;
      if (sent == stall_at && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else if (rand_rdy) begin
        rdy = 1'($urandom_range(0, 1));
      end
      if (poke_dreq && (sent == 25 || $urandom_range(0, 7) == 0)) dq = 1'b1;
      step(dq, rdy);
      guard++;
    end
    chk("frame_timeout", {31'd0, (guard < 400)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; dump_req = 1'b0; tx_ready = 1'b0;
    counters_flat = '0; cnt_next = '0;
    m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; sent = 0; xfers_seen = 0;
    #12;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero counters, ready always high.
    run_frame(1'b0, -1, 1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Known values in counters 0 and 10, then a stalled frame started in the done cycle.
    cnt_next[31:0]        = 32'h12345678;
    cnt_next[10*32 +: 32] = 32'hDEADBEEF;
    run_frame(1'b0, -1, 1'b0, 1'b0);
    run_frame(1'b0, 10, 1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Counters change every cycle during the frame.
    run_frame(1'b1, -1, 1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Requests during the frame set overrun; it persists until the next acceptance.
    run_frame(1'b0, -1, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_frame(1'b1, -1, 1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Asynchronous reset while byte 20 is presented, after an overrun has been flagged.
    for (int k = 0; k < N; k++) cnt_next[32*k +: 32] = $urandom;
    step(1'b1, 1'b1);
    while (m_busy && sent < 20) step((sent == 5) ? 1'b1 : 1'b0, 1'b1);
    #1 rst = 1'b1;
    dump_req = 1'b0;
    #1;
    chk("async_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_overrun", {31'd0, overrun}, 32'd0);
    chk("async_tx_data", {24'd0, tx_data}, 32'd0);
    exp_q.delete();
    m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; xfers_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1);
    run_frame(1'b0, -1, 1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Fully random frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) cnt_next[32*k +: 32] = $urandom;
      run_frame(1'b1, (f == 2) ? 7 : -1, 1'b1, 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--) step(1'b0, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
